// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count_sequencer run-control block.
//   state_t     : run-control state encoding, also presented on the state output
//   PER_*_DEF   : default prescaler reload values for a 50 MHz clock
//   period_sel  : maps the 2-bit speed switch to a prescaler reload value
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam int          PER_W_DEF = 28;
  localparam logic [27:0] PER_1_DEF = 28'd49999999;   // 1 Hz
  localparam logic [27:0] PER_2_DEF = 28'd99999999;   // 0.5 Hz
  localparam logic [27:0] PER_3_DEF = 28'd199999999;  // 0.25 Hz

  // Speed 00 reloads 0, so the prescaler expires on every cycle.
  function automatic logic [PER_W_DEF-1:0] period_sel(
    input logic [1:0]           spd,
    input logic [PER_W_DEF-1:0] p1,
    input logic [PER_W_DEF-1:0] p2,
    input logic [PER_W_DEF-1:0] p3
  );
    logic [PER_W_DEF-1:0] r;
    case (spd)
      2'b01:   r = p1;
      2'b10:   r = p2;
      2'b11:   r = p3;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/count_sequencer_prescaler_tick.sv
// prescaler_tick: loadable down-counter for the count_sequencer rate divider.
//   clk      in  system clock
//   reset    in  synchronous active-high reset, clears the count
//   clr      in  synchronous clear (abort), clears the count
//   load     in  load load_val (beats hold/decrement)
//   load_val in  reload value
//   hold     in  1 = keep the current count
//   zero     out count currently reads 0
module prescaler_tick #(
  parameter int PER_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [PER_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      // Saturates at 0; the owner reloads on zero while running.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run control for the rate divider and 4-bit HEX0 display counter.
//   CLOCK_50 in  system clock
//   reset    in  synchronous active-high reset
//   start    in  pulse: begin from IDLE/DONE, resume from PAUSED
//   pause    in  pulse: freeze while running
//   clear    in  pulse: abort to IDLE from any state
//   speed    in  speed select, applied at start and at every prescaler reload
//   dir      in  0 = count up, 1 = count down (captured at start)
//   limit    in  terminal value (captured at start)
//   digit    out current count value
//   tick     out one-cycle pulse per count step
//   busy     out high in RUN and PAUSED
//   done     out high in DONE
//   state    out IDLE=00 RUN=01 PAUSED=10 DONE=11
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int               PER_W = PER_W_DEF,
  parameter logic [PER_W-1:0] PER_1 = PER_W'(PER_1_DEF),
  parameter logic [PER_W-1:0] PER_2 = PER_W'(PER_2_DEF),
  parameter logic [PER_W-1:0] PER_3 = PER_W'(PER_3_DEF)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [1:0] speed,
  input  logic       dir,
  input  logic [3:0] limit,
  output logic [3:0] digit,
  output logic       tick,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [PER_W_DEF-1:0] P1 = PER_W_DEF'(PER_1);
  localparam logic [PER_W_DEF-1:0] P2 = PER_W_DEF'(PER_2);
  localparam logic [PER_W_DEF-1:0] P3 = PER_W_DEF'(PER_3);

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       tick_q, tick_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dir_q, dir_d;
  logic [3:0] limit_q, limit_d;

  logic             ps_clr, ps_load, ps_hold, ps_zero, run_step, terminal;
  logic [PER_W-1:0] reload;
  logic [3:0]       digit_step;

  // The reload always uses the live switch value, so a speed change takes
  // effect at the next reload rather than mid-period.
  assign reload     = PER_W'(period_sel(speed, P1, P2, P3));
  assign digit_step = dir_q ? (digit_q - 4'd1) : (digit_q + 4'd1);
  assign terminal   = dir_q ? (digit_step == 4'd0) : (digit_step == limit_q);

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    tick_d   = 1'b0;
    dir_d    = dir_q;
    limit_d  = limit_q;
    ps_clr   = 1'b0;
    ps_load  = 1'b0;
    run_step = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      digit_d = 4'd0;
      ps_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !pause) begin
            dir_d   = dir;
            limit_d = limit;
            digit_d = dir ? limit : 4'd0;
            ps_load = 1'b1;
            // Nothing to count with a zero limit in either direction.
            state_d = (limit == 4'd0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) state_d = ST_PAUSED;
          else       run_step = 1'b1;
        end
        ST_PAUSED: begin
          // The resume edge is itself a running cycle, so the paused
          // period finishes with the same number of running cycles.
          if (start && !pause) begin
            state_d  = ST_RUN;
            run_step = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (run_step && ps_zero) begin
        ps_load = 1'b1;
        tick_d  = 1'b1;
        digit_d = digit_step;
        if (terminal) state_d = ST_DONE;
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    done_d = (state_d == ST_DONE);
  end

  assign ps_hold = !run_step;

  prescaler_tick #(.PER_W(PER_W)) u_prescaler (
    .clk      (CLOCK_50),
    .reset    (reset),
    .clr      (ps_clr),
    .load     (ps_load),
    .load_val (reload),
    .hold     (ps_hold),
    .zero     (ps_zero)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      digit_q <= 4'd0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      limit_q <= 4'd0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
    end
  end

  assign digit = digit_q;
  assign tick  = tick_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, clear, dir;
  logic [1:0] speed;
  logic [3:0] limit;
  logic [3:0] digit;
  logic       tick, busy, done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_sequencer #(
    .PER_W (28),
    .PER_1 (28'd3),
    .PER_2 (28'd5),
    .PER_3 (28'd7)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .speed    (speed),
    .dir      (dir),
    .limit    (limit),
    .digit    (digit),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  // Advance one edge; inputs set before the call are sampled on that edge,
  // outputs read after the call reflect it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    total++;
    if ({state, busy, done, tick, digit} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {state, busy, done, tick, digit}, 9'b0);
    end
  endtask

  task automatic test_fast_up();
    speed = 2'b00; dir = 1'b0; limit = 4'd5;
    start = 1'b1; step(); start = 1'b0;
    total++;
    if ({state, busy, tick, digit} !== {2'b01, 1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL fast_start st=%b busy=%b tick=%b digit=%0d", state, busy, tick, digit);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (tick !== 1'b1 || digit !== 4'(i)) begin
        bad++;
        $display("FAIL fast_tick%0d tick=%b digit=%0d want tick=1 digit=%0d", i, tick, digit, i);
      end
      total++;
      if (i < 5 && (state !== 2'b01 || done !== 1'b0)) begin
        bad++;
        $display("FAIL fast_run%0d state=%b done=%b want 01/0", i, state, done);
      end else if (i == 5 && (state !== 2'b11 || done !== 1'b1 || busy !== 1'b0)) begin
        bad++;
        $display("FAIL fast_done state=%b done=%b busy=%b want 11/1/0", state, done, busy);
      end
    end
    step();
    total++;
    if ({state, done, tick, digit} !== {2'b11, 1'b1, 1'b0, 4'd5}) begin
      bad++;
      $display("FAIL fast_hold state=%b done=%b tick=%b digit=%0d want 11/1/0/5", state, done, tick, digit);
    end
  endtask

  task automatic test_slow_down();
    pulse_clear();
    speed = 2'b01; dir = 1'b1; limit = 4'd3;
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (digit !== 4'd3 || state !== 2'b01) begin
      bad++;
      $display("FAIL down_start digit=%0d state=%b want 3/01", digit, state);
    end
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        total++;
        if (tick !== 1'b0) begin
          bad++;
          $display("FAIL down_gap%0d_%0d tick=%b want 0", k, j, tick);
        end
      end
      step();
      total++;
      if (tick !== 1'b1 || digit !== 4'(3 - k)) begin
        bad++;
        $display("FAIL down_tick%0d tick=%b digit=%0d want 1/%0d", k, tick, digit, 3 - k);
      end
    end
    total++;
    if (state !== 2'b11 || done !== 1'b1) begin
      bad++;
      $display("FAIL down_done state=%b done=%b want 11/1", state, done);
    end
  endtask

  task automatic test_pause_resume();
    pulse_clear();
    speed = 2'b01; dir = 1'b0; limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    total++;
    if (tick !== 1'b1 || digit !== 4'd1) begin
      bad++;
      $display("FAIL pause_firsttick tick=%b digit=%0d want 1/1", tick, digit);
    end
    step();
    pause = 1'b1; step(); pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) pause = 1'b1;
      step();
      pause = 1'b0;
      total++;
      if ({state, busy, tick, digit} !== {2'b10, 1'b1, 1'b0, 4'd1}) begin
        bad++;
        $display("FAIL paused%0d state=%b busy=%b tick=%b digit=%0d want 10/1/0/1",
                 i, state, busy, tick, digit);
      end
    end
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (state !== 2'b01 || tick !== 1'b0) begin
      bad++;
      $display("FAIL resume state=%b tick=%b want 01/0", state, tick);
    end
    step();
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL resume_gap tick=%b want 0", tick);
    end
    step();
    total++;
    if (tick !== 1'b1 || digit !== 4'd2) begin
      bad++;
      $display("FAIL resume_tick tick=%b digit=%0d want 1/2", tick, digit);
    end
  endtask

  task automatic test_speed_change();
    pulse_clear();
    speed = 2'b01; dir = 1'b0; limit = 4'd15;
    start = 1'b1; step(); start = 1'b0;
    step();
    speed = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (tick !== 1'b0) begin
        bad++;
        $display("FAIL speed_oldperiod%0d tick=%b want 0", i, tick);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (tick !== 1'b1 || digit !== 4'(i)) begin
        bad++;
        $display("FAIL speed_fast%0d tick=%b digit=%0d want 1/%0d", i, tick, digit, i);
      end
    end
  endtask

  task automatic test_zero_limit();
    pulse_clear();
    speed = 2'b00; dir = 1'b0; limit = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    total++;
    if ({state, done, busy, tick, digit} !== {2'b11, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL zero_limit state=%b done=%b busy=%b tick=%b digit=%0d want 11/1/0/0/0",
               state, done, busy, tick, digit);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (tick !== 1'b0 || digit !== 4'd0) begin
        bad++;
        $display("FAIL zero_quiet%0d tick=%b digit=%0d want 0/0", i, tick, digit);
      end
    end
  endtask

  task automatic test_clear_reset();
    pulse_clear();
    speed = 2'b00; dir = 1'b0; limit = 4'd9;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    clear = 1'b1; pause = 1'b1; step(); clear = 1'b0; pause = 1'b0;
    total++;
    if ({state, busy, done, tick, digit} !== 9'b0) begin
      bad++;
      $display("FAIL clear_pause got=%b want=%b", {state, busy, done, tick, digit}, 9'b0);
    end
    step();
    total++;
    if (state !== 2'b00 || tick !== 1'b0) begin
      bad++;
      $display("FAIL clear_stays state=%b tick=%b want 00/0", state, tick);
    end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    total++;
    if (digit !== 4'd2 || state !== 2'b01) begin
      bad++;
      $display("FAIL rerun digit=%0d state=%b want 2/01", digit, state);
    end
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if ({state, busy, done, tick, digit} !== 9'b0) begin
      bad++;
      $display("FAIL midrun_reset got=%b want=%b", {state, busy, done, tick, digit}, 9'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    speed = 2'b00; dir = 1'b0; limit = 4'd0;
    test_reset();
    test_fast_up();
    test_slow_down();
    test_pause_resume();
    test_speed_change();
    test_zero_limit();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
